wb_port_arbiter: RTL and testbench

//  Shares the single writeback/ROB-completion port among NUM_REQ completing pipes
//  (ALU, MEM, MUL) that each carry a M/WB-style payload.
//  - One 1-entry buffer per requester; round-robin arbitration; registered output to the ROB write port.
//  - Sits between the pipe-final stage registers and the ROB.

---
 rtl/wb_port_arbiter_pkg.sv | 26 ++
 rtl/wb_port_arbiter_if.sv | 38 +++
 rtl/wb_port_arbiter_rr_arbiter.sv | 31 +++
 rtl/wb_port_arbiter.sv | 85 ++++++++
 tb/tb_wb_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the writeback-port arbiter: payload layout,
// requester indices and the round-robin pointer helper.
package wb_port_arbiter_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int ROB_ID_W   = 7;
    localparam int NUM_WB_REQ = 3;
    localparam int REQ_ALU    = 0;
    localparam int REQ_MEM    = 1;
    localparam int REQ_MUL    = 2;
    localparam int GRANT_W    = (NUM_WB_REQ > 1) ? $clog2(NUM_WB_REQ) : 1;

    typedef struct packed {
        logic [1:0]           instruction_type;
        logic [WORD_SIZE-1:0] pc;
        logic                 exception;
        logic [WORD_SIZE-1:0] virtual_addr_exc;
        logic [WORD_SIZE-1:0] result;
        logic [ROB_ID_W-1:0]  rob_id;
    } wb_payload_t;

    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx);
        return (idx == GRANT_W'(NUM_WB_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester-side payload bus and ROB write port of the writeback arbiter.
// The arbiter uses the slave modport; pipes and ROB together form the master side.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic [NUM_WB_REQ-1:0]           in_valid;
    logic [NUM_WB_REQ-1:0]           in_ready;
    logic [2*NUM_WB_REQ-1:0]         in_instruction_type;
    logic [WORD_SIZE*NUM_WB_REQ-1:0] in_pc;
    logic [NUM_WB_REQ-1:0]           in_exception;
    logic [WORD_SIZE*NUM_WB_REQ-1:0] in_virtual_addr_exc;
    logic [WORD_SIZE*NUM_WB_REQ-1:0] in_result;
    logic [ROB_ID_W*NUM_WB_REQ-1:0]  in_rob_id;

    logic                 out_valid;
    logic [1:0]           out_instruction_type;
    logic [WORD_SIZE-1:0] out_pc;
    logic                 out_exception;
    logic [WORD_SIZE-1:0] out_virtual_addr_exc;
    logic [WORD_SIZE-1:0] out_result;
    logic [ROB_ID_W-1:0]  out_rob_id;
    logic [GRANT_W-1:0]   out_grant_id;

    modport master (
        output in_valid, in_instruction_type, in_pc, in_exception,
               in_virtual_addr_exc, in_result, in_rob_id,
        input  in_ready, out_valid, out_instruction_type, out_pc, out_exception,
               out_virtual_addr_exc, out_result, out_rob_id, out_grant_id
    );

    modport slave (
        input  in_valid, in_instruction_type, in_pc, in_exception,
               in_virtual_addr_exc, in_result, in_rob_id,
        output in_ready, out_valid, out_instruction_type, out_pc, out_exception,
               out_virtual_addr_exc, out_result, out_rob_id, out_grant_id
    );

endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo N. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any_grant
);

    always_comb begin
        int j;
        j           = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (!o_any_grant && i_req[j]) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = IDX_W'(j);
                o_any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single ROB writeback port among the ALU/MEM/MUL pipes using a
// one-entry buffer per pipe, round-robin selection and a registered output.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    wb_port_arbiter_if.slave wb
);

    wb_payload_t           w_in_pl [NUM_WB_REQ];
    wb_payload_t           r_buf   [NUM_WB_REQ];
    logic [NUM_WB_REQ-1:0] r_buf_valid;
    logic [GRANT_W-1:0]    r_rr_ptr;
    logic [NUM_WB_REQ-1:0] w_grant;
    logic [GRANT_W-1:0]    w_grant_idx;
    logic                  w_any_grant;
    logic [NUM_WB_REQ-1:0] w_in_ready;
    logic [NUM_WB_REQ-1:0] w_accept;
    wb_payload_t           r_out;
    logic                  r_out_valid;
    logic [GRANT_W-1:0]    r_grant_id;

    always_comb begin
        for (int i = 0; i < NUM_WB_REQ; i++) begin
            w_in_pl[i].instruction_type = wb.in_instruction_type[2*i +: 2];
            w_in_pl[i].pc               = wb.in_pc[WORD_SIZE*i +: WORD_SIZE];
            w_in_pl[i].exception        = wb.in_exception[i];
            w_in_pl[i].virtual_addr_exc = wb.in_virtual_addr_exc[WORD_SIZE*i +: WORD_SIZE];
            w_in_pl[i].result           = wb.in_result[WORD_SIZE*i +: WORD_SIZE];
            w_in_pl[i].rob_id           = wb.in_rob_id[ROB_ID_W*i +: ROB_ID_W];
        end
    end

    rr_arbiter #(.N(NUM_WB_REQ), .IDX_W(GRANT_W)) u_rr_arbiter (
        .i_req       (r_buf_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    // A granted slot drains this edge, so it may be refilled in the same cycle.
    assign w_in_ready = (reset || flush) ? '0 : (~r_buf_valid | w_grant);
    assign w_accept   = wb.in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WB_REQ; i++) begin
            if (w_accept[i]) r_buf[i] <= w_in_pl[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf_valid <= '0;
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_grant_id  <= '0;
        end else if (flush) begin
            r_buf_valid <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_buf_valid <= (r_buf_valid & ~w_grant) | w_accept;
            r_out_valid <= w_any_grant;
            if (w_any_grant) begin
                r_out      <= r_buf[w_grant_idx];
                r_grant_id <= w_grant_idx;
                r_rr_ptr   <= rr_next(w_grant_idx);
            end
        end
    end

    assign wb.in_ready             = w_in_ready;
    assign wb.out_valid            = r_out_valid;
    assign wb.out_instruction_type = r_out.instruction_type;
    assign wb.out_pc               = r_out.pc;
    assign wb.out_exception        = r_out.exception;
    assign wb.out_virtual_addr_exc = r_out.virtual_addr_exc;
    assign wb.out_result           = r_out.result;
    assign wb.out_rob_id           = r_out.rob_id;
    assign wb.out_grant_id         = r_grant_id;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus random traffic checked by a
// queue-based scoreboard fed from a transaction-level reference model.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int N = NUM_WB_REQ;

    logic clk;
    logic reset;
    logic flush;

    wb_port_arbiter_if u_if ();

    wb_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .wb    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        wb_payload_t p;
        int          id;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    wb_payload_t m_buf [N];
    logic [N-1:0] m_occ = '0;
    int          m_rr  = 0;
    int          cyc   = 0;
    int          out_cnt [N];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic wb_payload_t in_payload(input int i);
        wb_payload_t p;
        p.instruction_type = u_if.in_instruction_type[2*i +: 2];
        p.pc               = u_if.in_pc[WORD_SIZE*i +: WORD_SIZE];
        p.exception        = u_if.in_exception[i];
        p.virtual_addr_exc = u_if.in_virtual_addr_exc[WORD_SIZE*i +: WORD_SIZE];
        p.result           = u_if.in_result[WORD_SIZE*i +: WORD_SIZE];
        p.rob_id           = u_if.in_rob_id[ROB_ID_W*i +: ROB_ID_W];
        return p;
    endfunction

    function automatic wb_payload_t out_payload();
        wb_payload_t p;
        p.instruction_type = u_if.out_instruction_type;
        p.pc               = u_if.out_pc;
        p.exception        = u_if.out_exception;
        p.virtual_addr_exc = u_if.out_virtual_addr_exc;
        p.result           = u_if.out_result;
        p.rob_id           = u_if.out_rob_id;
        return p;
    endfunction

    // Reference: the occupied entry nearest at/after the pointer (mod N) wins.
    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (m_occ[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        if (reset || flush) return '0;
        r = ~m_occ;
        g = model_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int g;
        logic [N-1:0] acc;
        cyc = cyc + 1;
        if (reset) begin
            m_occ = '0;
            m_rr  = 0;
        end else if (flush) begin
            m_occ = '0;
        end else begin
            g   = model_grant();
            acc = u_if.in_valid & model_ready();
            if (g >= 0) begin
                q.push_back('{p: m_buf[g], id: g, cyc: cyc});
                m_occ[g] = 1'b0;
                m_rr     = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    m_buf[i] = in_payload(i);
                    m_occ[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        chk("in_ready", u_if.in_ready, model_ready());
        if (u_if.out_valid === 1'b1) begin
            if (u_if.out_grant_id < N) out_cnt[u_if.out_grant_id]++;
            if (q.size() == 0) begin
                chk("sb_unexpected_out_rob_id", u_if.out_rob_id, 'x);
            end else begin
                e = q.pop_front();
                n_checks++;
                if (out_payload() !== e.p || int'(u_if.out_grant_id) != e.id || cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL sb_out: got cyc %0d id %0d pl %h expected cyc %0d id %0d pl %h",
                             cyc, u_if.out_grant_id, out_payload(), e.cyc, e.id, e.p);
                end
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("sb_missing_out_valid", u_if.out_valid, 1'b1);
        end
    end

    task automatic clear_inputs();
        u_if.in_valid            = '0;
        u_if.in_instruction_type = '0;
        u_if.in_pc               = '0;
        u_if.in_exception        = '0;
        u_if.in_virtual_addr_exc = '0;
        u_if.in_result           = '0;
        u_if.in_rob_id           = '0;
    endtask

    task automatic drive_req(input int i, input wb_payload_t p);
        u_if.in_valid[i]                                  = 1'b1;
        u_if.in_instruction_type[2*i +: 2]                = p.instruction_type;
        u_if.in_pc[WORD_SIZE*i +: WORD_SIZE]              = p.pc;
        u_if.in_exception[i]                              = p.exception;
        u_if.in_virtual_addr_exc[WORD_SIZE*i +: WORD_SIZE] = p.virtual_addr_exc;
        u_if.in_result[WORD_SIZE*i +: WORD_SIZE]          = p.result;
        u_if.in_rob_id[ROB_ID_W*i +: ROB_ID_W]            = p.rob_id;
    endtask

    function automatic wb_payload_t rand_pl();
        wb_payload_t p;
        p.instruction_type = 2'($urandom_range(0, 3));
        p.pc               = $urandom;
        p.exception        = 1'($urandom_range(0, 1));
        p.virtual_addr_exc = $urandom;
        p.result           = $urandom;
        p.rob_id           = ROB_ID_W'($urandom_range(0, 127));
        return p;
    endfunction

    function automatic wb_payload_t mk_pl(input int rob, input logic [31:0] res, input logic [31:0] pc);
        wb_payload_t p;
        p                  = '0;
        p.rob_id           = ROB_ID_W'(rob);
        p.result           = res;
        p.pc               = pc;
        return p;
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        wb_payload_t p;
        int acc_cnt [2];
        int guard;
        reset = 1'b1;
        flush = 1'b0;
        clear_inputs();
        for (int i = 0; i < N; i++) out_cnt[i] = 0;
        step(3);
        reset = 1'b0;
        chk("reset_out_valid", u_if.out_valid, 1'b0);
        chk("reset_out_rob_id", u_if.out_rob_id, 0);
        chk("reset_out_result", u_if.out_result, 0);

        // Single ALU request: output appears exactly two cycles later.
        step();
        drive_req(REQ_ALU, mk_pl(5, 32'hDEADBEEF, 32'h100));
        step();
        clear_inputs();
        chk("t1_out_valid_c1", u_if.out_valid, 1'b0);
        step();
        chk("t1_out_valid_c2", u_if.out_valid, 1'b1);
        chk("t1_rob_id", u_if.out_rob_id, 5);
        chk("t1_result", u_if.out_result, 32'hDEADBEEF);
        chk("t1_pc", u_if.out_pc, 32'h100);
        chk("t1_grant_id", u_if.out_grant_id, 0);
        step();
        chk("t1_out_valid_c3", u_if.out_valid, 1'b0);

        // All three at once after reset: rob 1,2,3 in order.
        do_reset();
        step();
        for (int i = 0; i < N; i++) drive_req(i, mk_pl(i + 1, 32'h10 + 32'(i), 32'h200 + 32'(i)));
        step();
        clear_inputs();
        #1 chk("t2_in_ready_c1", u_if.in_ready, 3'b001);
        step();
        chk("t2_rob_c2", u_if.out_rob_id, 1);
        #1 chk("t2_in_ready_c2", u_if.in_ready, 3'b011);
        step();
        chk("t2_rob_c3", u_if.out_rob_id, 2);
        step();
        chk("t2_rob_c4", u_if.out_rob_id, 3);
        chk("t2_valid_c4", u_if.out_valid, 1'b1);
        step(2);

        // ALU and MEM streaming: 20 results per port.
        for (int i = 0; i < N; i++) out_cnt[i] = 0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        guard = 0;
        while ((acc_cnt[0] < 20 || acc_cnt[1] < 20) && guard < 200) begin
            step();
            clear_inputs();
            for (int i = 0; i < 2; i++) if (acc_cnt[i] < 20) drive_req(i, rand_pl());
            #1;
            for (int i = 0; i < 2; i++) if (u_if.in_valid[i] && u_if.in_ready[i]) acc_cnt[i]++;
            guard++;
        end
        chk("t3_stream_in_time", guard < 200, 1'b1);
        step();
        clear_inputs();
        step(4);
        chk("t3_alu_count", out_cnt[REQ_ALU], 20);
        chk("t3_mem_count", out_cnt[REQ_MEM], 20);
        chk("t3_mul_count", out_cnt[REQ_MUL], 0);

        // Flush with every buffer full.
        for (int i = 0; i < N; i++) drive_req(i, rand_pl());
        step();
        for (int i = 0; i < N; i++) drive_req(i, rand_pl());
        step();
        clear_inputs();
        flush = 1'b1;
        #1 chk("t4_in_ready_during_flush", u_if.in_ready, 3'b000);
        step();
        flush = 1'b0;
        chk("t4_out_valid_after_flush", u_if.out_valid, 1'b0);
        #1 chk("t4_in_ready_after_flush", u_if.in_ready, 3'b111);
        step();
        chk("t4_out_valid_later", u_if.out_valid, 1'b0);

        // Reset mid-stream: rr pointer returns to ALU.
        drive_req(REQ_MUL, rand_pl());
        step();
        clear_inputs();
        step();
        for (int i = 0; i < N; i++) drive_req(i, rand_pl());
        step();
        for (int i = 0; i < N; i++) drive_req(i, rand_pl());
        reset = 1'b1;
        #1 chk("t5_in_ready_during_reset", u_if.in_ready, 3'b000);
        step();
        reset = 1'b0;
        clear_inputs();
        chk("t5_out_valid_after_reset", u_if.out_valid, 1'b0);
        chk("t5_out_rob_after_reset", u_if.out_rob_id, 0);
        #1 chk("t5_in_ready_after_reset", u_if.in_ready, 3'b111);
        for (int i = 0; i < N; i++) drive_req(i, mk_pl(10 + i, 32'h0, 32'h0));
        step();
        clear_inputs();
        step();
        chk("t5_first_grant", u_if.out_grant_id, REQ_ALU);
        chk("t5_first_rob", u_if.out_rob_id, 10);
        step(3);

        // MEM exception payload passes through unchanged.
        p = mk_pl(42, 32'h0, 32'h300);
        p.exception        = 1'b1;
        p.virtual_addr_exc = 32'h0000_1000;
        drive_req(REQ_MEM, p);
        step();
        clear_inputs();
        step();
        chk("t6_valid", u_if.out_valid, 1'b1);
        chk("t6_exception", u_if.out_exception, 1'b1);
        chk("t6_vaddr", u_if.out_virtual_addr_exc, 32'h0000_1000);
        chk("t6_grant_id", u_if.out_grant_id, REQ_MEM);
        step(2);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 400; c++) begin
            step();
            clear_inputs();
            for (int i = 0; i < N; i++) if ($urandom_range(0, 99) < 60) drive_req(i, rand_pl());
            flush = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 149) == 0);
        end
        step();
        clear_inputs();
        flush = 1'b0;
        reset = 1'b0;
        step(6);
        chk("sb_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
